// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide sequencer: op codes,
// sequencer states and the default operand width.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ITER  = 2'd2,
        S_FIXUP = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// EX-stage / hazard-unit side of the multiply/divide sequencer and HI/LO pair.
interface muldiv_hilo_ctrl_if #(
    parameter int WIDTH = muldiv_pkg::WIDTH_DEF
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             abort;
    logic             mf_req;
    logic             mt_we;
    logic             mt_sel;
    logic [WIDTH-1:0] mt_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             mult_ready;
    logic             done;
    logic             stall_req;

    modport master (
        output start, op, rs_val, rt_val, abort, mf_req, mt_we, mt_sel, mt_data,
        input  hi, lo, mult_ready, done, stall_req
    );

    modport slave (
        input  start, op, rs_val, rt_val, abort, mf_req, mt_we, mt_sel, mt_data,
        output hi, lo, mult_ready, done, stall_req
    );
endinterface

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
// acc = {partial product | remainder, multiplier | quotient bits}.
module muldiv_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] next_acc
);
    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] rem_sh_s;
    logic [WIDTH:0] diff_s;

    // The remainder keeps one extra bit after the shift so the compare never overflows
    always_comb begin
        sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
        rem_sh_s = acc[2*WIDTH-1:WIDTH-1];
        diff_s   = rem_sh_s - {1'b0, operand};
        if (is_div) begin
            if (diff_s[WIDTH]) begin
                next_acc = {rem_sh_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                next_acc = {diff_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            next_acc = {sum_s, acc[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Sequencer for the shared iterative multiply/divide unit and the HI/LO pair,
// with interlocks for MFHI/MFLO/MTHI/MTLO against an op in flight.
module muldiv_hilo_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_hilo_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_e             state_r;
    op_e                op_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   operand_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [CW-1:0]      cnt_r;
    logic               neg_lo_r;
    logic               neg_hi_r;
    logic               divz_r;
    logic               done_r;
    logic               ready_r;

    logic               is_div_s;
    logic               is_signed_s;
    logic               busy_s;
    logic               accept_s;
    logic [WIDTH-1:0]   abs_a_s;
    logic [WIDTH-1:0]   abs_b_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;
    logic [2*WIDTH-1:0] step_s;
    logic [2*WIDTH-1:0] neg_step_s;

    muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_r),
        .operand  (operand_r),
        .is_div   (is_div_s),
        .next_acc (step_s)
    );

    // Op decode; during LOAD acc_r[WIDTH-1:0] holds raw rs and operand_r raw rt
    always_comb begin
        is_div_s    = (op_r == OP_DIV) || (op_r == OP_DIVU);
        is_signed_s = (op_r == OP_MULT) || (op_r == OP_DIV);
        busy_s      = (state_r == S_LOAD) || (state_r == S_ITER);
        accept_s    = bus.start && !bus.abort && !busy_s;
        abs_a_s     = (is_signed_s && acc_r[WIDTH-1]) ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
        abs_b_s     = (is_signed_s && operand_r[WIDTH-1]) ? -operand_r : operand_r;
    end

    // Sign correction of the last iteration's result; divide by zero stays raw
    always_comb begin
        neg_step_s = -step_s;
        res_hi_s   = step_s[2*WIDTH-1:WIDTH];
        res_lo_s   = step_s[WIDTH-1:0];
        if (!is_div_s) begin
            if (neg_lo_r) begin
                res_hi_s = neg_step_s[2*WIDTH-1:WIDTH];
                res_lo_s = neg_step_s[WIDTH-1:0];
            end else begin
                res_hi_s = step_s[2*WIDTH-1:WIDTH];
                res_lo_s = step_s[WIDTH-1:0];
            end
        end else if (divz_r) begin
            res_hi_s = step_s[2*WIDTH-1:WIDTH];
            res_lo_s = step_s[WIDTH-1:0];
        end else begin
            res_lo_s = neg_lo_r ? -step_s[WIDTH-1:0] : step_s[WIDTH-1:0];
            res_hi_s = neg_hi_r ? -step_s[2*WIDTH-1:WIDTH] : step_s[2*WIDTH-1:WIDTH];
        end
    end

    // Sequencer FSM, iteration registers and architectural HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            op_r      <= OP_MULT;
            acc_r     <= {(2*WIDTH){1'b0}};
            operand_r <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            cnt_r     <= {CW{1'b0}};
            neg_lo_r  <= 1'b0;
            neg_hi_r  <= 1'b0;
            divz_r    <= 1'b0;
            done_r    <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE, S_FIXUP: begin
                    if (accept_s) begin
                        state_r   <= S_LOAD;
                        op_r      <= op_e'(bus.op);
                        acc_r     <= {{WIDTH{1'b0}}, bus.rs_val};
                        operand_r <= bus.rt_val;
                        ready_r   <= 1'b0;
                    end else begin
                        state_r   <= S_IDLE;
                    end
                    // HI/LO were just written by the op in FIXUP, so a coincident MT write is dropped
                    if ((state_r == S_IDLE) && bus.mt_we) begin
                        if (bus.mt_sel) begin
                            hi_r <= bus.mt_data;
                        end else begin
                            lo_r <= bus.mt_data;
                        end
                    end
                end
                S_LOAD: begin
                    if (bus.abort) begin
                        state_r <= S_IDLE;
                        ready_r <= 1'b1;
                    end else begin
                        acc_r     <= {{WIDTH{1'b0}}, (is_div_s ? abs_a_s : abs_b_s)};
                        operand_r <= is_div_s ? abs_b_s : abs_a_s;
                        neg_lo_r  <= is_signed_s && (acc_r[WIDTH-1] ^ operand_r[WIDTH-1]);
                        neg_hi_r  <= is_signed_s && acc_r[WIDTH-1];
                        divz_r    <= is_div_s && (operand_r == {WIDTH{1'b0}});
                        cnt_r     <= CW'(WIDTH - 1);
                        state_r   <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (bus.abort) begin
                        state_r <= S_IDLE;
                        ready_r <= 1'b1;
                    end else begin
                        acc_r <= step_s;
                        if (cnt_r == {CW{1'b0}}) begin
                            hi_r    <= res_hi_s;
                            lo_r    <= res_lo_s;
                            done_r  <= 1'b1;
                            ready_r <= 1'b1;
                            state_r <= S_FIXUP;
                        end else begin
                            cnt_r <= cnt_r - CW'(1);
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.hi         = hi_r;
    assign bus.lo         = lo_r;
    assign bus.done       = done_r;
    assign bus.mult_ready = ready_r;
    assign bus.stall_req  = busy_s && (bus.mf_req || bus.mt_we);

endmodule
